// File: rtl/switch_debouncer.sv
// Purpose: 2-flop synchroniser plus per-bit stability-counter debouncer for slide switches, with rise/fall/change pulses.
// Latency: a new stable level first sampled on edge 1 reaches sw_db (and the pulses) on edge STABLE_CYCLES+2.
// Backpressure: none; free-running, the outputs are registered levels and single-cycle pulses.
module switch_debouncer #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] switch,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_change
);

  // Terminal count: the bit flips on the edge where its counter already holds this value.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  // Reject illegal builds at elaboration rather than producing a silently wrapping counter.
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535) begin : g_bad_stable
    $error("switch_debouncer: STABLE_CYCLES out of range 1..65535");
  end
  if ((64'd1 << CNT_W) <= 64'(STABLE_CYCLES - 1)) begin : g_bad_cnt_w
    $error("switch_debouncer: CNT_W too narrow for STABLE_CYCLES-1");
  end

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] db_q;
  logic [WIDTH-1:0] db_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic             change_q;
  logic             change_d;

  // Per-bit stability counting: any cycle back at the debounced level restarts the count.
  always_comb begin
    cnt_d    = cnt_q;
    db_d     = db_q;
    rise_d   = '0;
    fall_d   = '0;
    change_d = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]   = s2_q[i];
        cnt_d[i]  = '0;
        rise_d[i] = s2_q[i];
        fall_d[i] = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    change_d = |(rise_d | fall_d);
  end

  // Synchroniser, counters, debounced level and pulse registers; synchronous active-low reset discards all of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      db_q     <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= switch;
      s2_q     <= s1_q;
      db_q     <= db_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= change_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_db     = db_q;
  assign sw_rise   = rise_q;
  assign sw_fall   = fall_q;
  assign sw_change = change_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer: STABLE_CYCLES=4 instance for the main sequence,
// plus a STABLE_CYCLES=1 instance for the minimum-latency build.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled there too.
module tb_switch_debouncer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] switch;
  logic [7:0] sw_db, sw_rise, sw_fall;
  logic       sw_change;
  logic [7:0] sw1;
  logic [7:0] db1, rise1, fall1;
  logic       change1;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  switch_debouncer #(.WIDTH(8), .STABLE_CYCLES(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .switch(switch),
    .sw_db(sw_db), .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_change(sw_change)
  );

  switch_debouncer #(.WIDTH(8), .STABLE_CYCLES(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .switch(sw1),
    .sw_db(db1), .sw_rise(rise1), .sw_fall(fall1), .sw_change(change1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check all four outputs of the main instance at once.
  task automatic check_all(input string tag, input logic [7:0] db, input logic [7:0] ri,
                           input logic [7:0] fa, input logic ch);
    check({tag, ".db"},   sw_db, db);
    check({tag, ".rise"}, sw_rise, ri);
    check({tag, ".fall"}, sw_fall, fa);
    check({tag, ".chg"},  {7'd0, sw_change}, {7'd0, ch});
  endtask

  initial begin
    logic [5:0] bounce;
    bounce = 6'b011011;   // bit k = value sampled on bounce edge k+1: 1,1,0,1,1,0

    // 1. Reset held 3 edges with switches up; everything reads 0.
    rst_n  = 1'b0;
    switch = 8'hFF;
    sw1    = 8'h00;
    for (int e = 1; e <= 3; e++) begin
      step();
      check_all($sformatf("rst_e%0d", e), 8'h00, 8'h00, 8'h00, 1'b0);
      check("rst.db1", db1, 8'h00);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      check_all($sformatf("rel_e%0d", e), 8'h00, 8'h00, 8'h00, 1'b0);
    end
    step();
    check_all("rel_e6", 8'hFF, 8'hFF, 8'h00, 1'b1);
    step();
    check_all("rel_e7", 8'hFF, 8'h00, 8'h00, 1'b0);

    // 2. Bring everything down, then a clean single-bit rise.
    switch = 8'h00;
    repeat (6) step();
    check_all("down_e6", 8'h00, 8'h00, 8'hFF, 1'b1);
    step();
    check_all("down_e7", 8'h00, 8'h00, 8'h00, 1'b0);
    switch = 8'h01;
    for (int e = 1; e <= 5; e++) begin
      step();
      check_all($sformatf("one_e%0d", e), 8'h00, 8'h00, 8'h00, 1'b0);
    end
    step();
    check_all("one_e6", 8'h01, 8'h01, 8'h00, 1'b1);
    step();
    check_all("one_e7", 8'h01, 8'h00, 8'h00, 1'b0);

    // 3. Bounce on bit 3; final stable 1 first sampled on edge 7, so the flip lands on edge 12.
    for (int k = 0; k < 6; k++) begin
      switch = {4'h0, bounce[k], 3'b001};
      step();
      check_all($sformatf("bnc_e%0d", k + 1), 8'h01, 8'h00, 8'h00, 1'b0);
    end
    switch = 8'h09;
    for (int e = 7; e <= 11; e++) begin
      step();
      check_all($sformatf("bnc_e%0d", e), 8'h01, 8'h00, 8'h00, 1'b0);
    end
    step();
    check_all("bnc_e12", 8'h09, 8'h08, 8'h00, 1'b1);
    step();
    check_all("bnc_e13", 8'h09, 8'h00, 8'h00, 1'b0);

    // 4. From 0F, all eight bits flip together on one edge.
    switch = 8'h0F;
    repeat (6) step();
    check_all("to0F_e6", 8'h0F, 8'h06, 8'h00, 1'b1);
    step();
    switch = 8'hF0;
    for (int e = 1; e <= 5; e++) begin
      step();
      check_all($sformatf("multi_e%0d", e), 8'h0F, 8'h00, 8'h00, 1'b0);
    end
    step();
    check_all("multi_e6", 8'hF0, 8'hF0, 8'h0F, 1'b1);
    step();
    check_all("multi_e7", 8'hF0, 8'h00, 8'h00, 1'b0);

    // 5. Reset pulse on edge 4 of a count; the count restarts after release.
    switch = 8'h00;
    repeat (6) step();
    check_all("to00_e6", 8'h00, 8'h00, 8'hF0, 1'b1);
    step();
    switch = 8'h80;
    for (int e = 1; e <= 3; e++) begin
      step();
      check_all($sformatf("mid_e%0d", e), 8'h00, 8'h00, 8'h00, 1'b0);
    end
    rst_n = 1'b0;
    step();
    check_all("mid_rst", 8'h00, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      check_all($sformatf("mid_rel_e%0d", e), 8'h00, 8'h00, 8'h00, 1'b0);
    end
    step();
    check_all("mid_rel_e6", 8'h80, 8'h80, 8'h00, 1'b1);
    step();
    check_all("mid_rel_e7", 8'h80, 8'h00, 8'h00, 1'b0);

    // 6. STABLE_CYCLES=1: a step reaches sw_db on edge 3.
    sw1 = 8'h01;
    step();
    check("s1_up_e1.db", db1, 8'h00);
    step();
    check("s1_up_e2.db", db1, 8'h00);
    check("s1_up_e2.rise", rise1, 8'h00);
    step();
    check("s1_up_e3.db", db1, 8'h01);
    check("s1_up_e3.rise", rise1, 8'h01);
    check("s1_up_e3.chg", {7'd0, change1}, 8'h01);
    step();
    check("s1_up_e4.rise", rise1, 8'h00);
    check("s1_up_e4.chg", {7'd0, change1}, 8'h00);
    sw1 = 8'h00;
    step();
    step();
    check("s1_dn_e2.db", db1, 8'h01);
    step();
    check("s1_dn_e3.db", db1, 8'h00);
    check("s1_dn_e3.fall", fall1, 8'h01);
    check("s1_dn_e3.chg", {7'd0, change1}, 8'h01);
    step();
    check("s1_dn_e4.fall", fall1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Upstream conditioning stage for the board's 8 slide switches; its output feeds the switch-to-LED stage in place of raw switch pins.
- Each bit is synchronised into the clock domain through a 2-flop chain.
- Each bit is then debounced by its own stability counter.
- One-cycle rise/fall pulses are emitted per bit, plus a combined change pulse for downstream logic.

Parameters:
- WIDTH, 8, number of independent switch bits.
- STABLE_CYCLES, 50000, consecutive cycles a synchronised bit must differ from its debounced value before the debounced value flips (1 ms at 50 MHz). Legal range is 1 to 65535.
- CNT_W, 16, per-bit counter width. Must satisfy 2^CNT_W > STABLE_CYCLES-1.

Ports:
- clk  input  1  system clock; all state is updated on its rising edge.
- rst_n  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- switch  input  WIDTH  raw asynchronous switch levels.
- sw_db  output  WIDTH  debounced switch levels, registered.
- sw_rise  output  WIDTH  one-cycle pulse per bit when sw_db bit goes 0->1.
- sw_fall  output  WIDTH  one-cycle pulse per bit when sw_db bit goes 1->0.
- sw_change  output  1  one-cycle pulse, OR of sw_rise|sw_fall.

Behaviour:
- Reset: on a clk edge with rst_n=0, clear all of the following. All outputs stay 0 while rst_n is held low.
  - sync stage 1 and stage 2 registers
  - per-bit counters
  - sw_db, sw_rise, sw_fall, sw_change
- Reset mid-count or mid-pulse: any in-progress count and any pulse are discarded.
- After reset release, a switch already held at 1 is treated as a normal 0->1 change and produces sw_rise.
- Synchroniser: s1 <= switch; s2 <= s1. No other logic reads switch or s1.
- Per-bit counter (bits fully independent), evaluated each edge, rst_n=1:
  - s2[i]==sw_db[i]: cnt[i] <= 0; no change to sw_db[i].
  - s2[i]!=sw_db[i] and cnt[i] < STABLE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s2[i]!=sw_db[i] and cnt[i]==STABLE_CYCLES-1: sw_db[i] <= s2[i]; cnt[i] <= 0; assert the matching rise or fall pulse on the same edge.
- Glitch rejection: any cycle where s2[i] returns to sw_db[i] clears cnt[i]. The full STABLE_CYCLES count restarts on the next difference.
- Latency:
  - Call the edge that first samples a new stable level edge 1.
  - sw_db updates on edge STABLE_CYCLES+2.
  - Example: STABLE_CYCLES=4 gives sw_db update on edge 6.
- Pulses:
  - sw_rise, sw_fall and sw_change are registered and high for exactly one cycle, coincident with the first cycle of the new sw_db value.
  - They are cleared on the next edge unless that bit flips again. A re-flip requires at least STABLE_CYCLES further cycles, so a bit never pulses in consecutive cycles when STABLE_CYCLES>=2.
- Simultaneous events: several bits may flip on the same edge; each sets its own rise/fall bit, and sw_change is a single pulse.
- Counter saturation: the counter never exceeds STABLE_CYCLES-1, so no wrap-around occurs.
- STABLE_CYCLES=1: sw_db follows s2 with one extra register delay.

Test Plan (STABLE_CYCLES=4, WIDTH=8 unless noted):
1. Reset: hold rst_n=0 for 3 edges with switch=8'hFF.
   - During reset, all outputs are 0.
   - After release with switch held at 8'hFF, sw_db=8'hFF on the 6th edge after release, with sw_rise=8'hFF and sw_change=1 for exactly one cycle.
2. Clean single-bit change: sw_db=8'h00, set switch=8'h01 just before edge 1.
   - sw_db becomes 8'h01 after edge 6.
   - sw_rise=8'h01 for one cycle; sw_fall=0.
3. Bounce rejection: toggle switch[3] in the pattern 1,1,0,1,1,0 on successive edges, then hold it at 1.
   - sw_db[3] does not change during the bounce.
   - sw_db[3] rises only 6 edges after the final stable 1 is first sampled; exactly one sw_rise[3] pulse.
4. Simultaneous multi-bit change: sw_db=8'h0F, switch changes to 8'hF0.
   - Single update edge: sw_db=8'hF0, sw_rise=8'hF0, sw_fall=8'h0F, sw_change=1 for one cycle.
5. Reset mid-count: switch goes 8'h00 -> 8'h80, and rst_n is pulsed low on edge 4.
   - No pulse occurs, and the count restarts from zero.
   - sw_db=8'h80 appears 6 edges after reset release.
6. STABLE_CYCLES=1 build: a switch step reaches sw_db on edge 3, with a one-cycle pulse.
